// File: rtl/ram64_arbiter_pkg.sv
// Shared definitions for the RAM64 two-port arbiter.
//   DATA_W / ADDR_W / DEPTH : RAM64 geometry (16-bit words, 64 entries)
//   CNT_W                   : clear-sweep counter width (must reach DEPTH)
//   state_e                 : arbiter FSM encoding (INIT=0, IDLE=1, ACC=2)
package ram64_arbiter_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
    localparam int CNT_W  = 7;

    // Counter value at which the sweep has written every address.
    localparam logic [CNT_W-1:0] SWEEP_END = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_ACC  = 2'd2
    } state_e;

endpackage

// File: rtl/ram64_arbiter_rr_arb2.sv
// Combinational 2-way round-robin chooser.
//   eligible[1:0] : per-requester eligibility
//   prio          : requester that wins when both are eligible
//   valid         : at least one requester is eligible
//   winner        : index of the granted requester (meaningful when valid)
module rr_arb2 (
    input  logic [1:0] eligible,
    input  logic       prio,
    output logic       valid,
    output logic       winner
);

    // Pick the single eligible requester, or the prioritised one on a tie.
    always_comb begin
        valid  = |eligible;
        winner = 1'b0;
        case (eligible)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = prio;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/ram64_arbiter.sv
// Two-port front end for one RAM64 (16-bit data, 6-bit address, combinational
// read). Clears the RAM after reset, then shares it between two requesters
// with round-robin priority. Every RAM input comes straight from a register.
//   clk, rst_n                          : clock, synchronous active-low reset
//   req_x, we_x, addr_x, wdata_x        : requester x access (held until ack_x)
//   ack_x, rdata_x                      : one-cycle completion, read data
//   ram_in, ram_load, ram_address       : registered RAM64 inputs
//   ram_out                             : RAM64 combinational read data
//   busy                                : high during reset and the clear sweep
module ram64_arbiter
    import ram64_arbiter_pkg::*;
#(
    parameter bit                CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0] INIT_VALUE     = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_0,
    input  logic              we_0,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [DATA_W-1:0] wdata_0,
    output logic              ack_0,
    output logic [DATA_W-1:0] rdata_0,
    input  logic              req_1,
    input  logic              we_1,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_1,
    output logic              ack_1,
    output logic [DATA_W-1:0] rdata_1,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    input  logic [DATA_W-1:0] ram_out,
    output logic              busy
);

    localparam state_e RESET_STATE = CLEAR_ON_RESET ? ST_INIT : ST_IDLE;

    state_e            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              prio_r, prio_s;
    logic              owner_r, owner_s;
    logic [ADDR_W-1:0] ram_address_r, ram_address_s;
    logic [DATA_W-1:0] ram_in_r, ram_in_s;
    logic              ram_load_r, ram_load_s;
    logic              ack_0_r, ack_0_s, ack_1_r, ack_1_s;
    logic [DATA_W-1:0] rdata_0_r, rdata_0_s, rdata_1_r, rdata_1_s;
    logic              busy_r, busy_s;
    logic [1:0]        eligible_s;
    logic              grant_valid_s;
    logic              winner_s;

    // A request being acknowledged this cycle must not be granted again.
    assign eligible_s = {req_1 & ~ack_1_r, req_0 & ~ack_0_r};

    rr_arb2 u_rr_arb2 (
        .eligible (eligible_s),
        .prio     (prio_r),
        .valid    (grant_valid_s),
        .winner   (winner_s)
    );

    // Next-state and next-output logic for the sweep / arbitrate / access FSM.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        prio_s        = prio_r;
        owner_s       = owner_r;
        ram_address_s = ram_address_r;
        ram_in_s      = ram_in_r;
        ram_load_s    = 1'b0;
        ack_0_s       = 1'b0;
        ack_1_s       = 1'b0;
        rdata_0_s     = rdata_0_r;
        rdata_1_s     = rdata_1_r;
        busy_s        = busy_r;
        case (state_r)
            ST_INIT: begin
                if (cnt_r == SWEEP_END) begin
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    ram_address_s = cnt_r[ADDR_W-1:0];
                    ram_in_s      = INIT_VALUE;
                    ram_load_s    = 1'b1;
                    cnt_s         = cnt_r + 7'd1;
                end
            end
            ST_IDLE: begin
                busy_s = 1'b0;
                if (grant_valid_s) begin
                    owner_s       = winner_s;
                    prio_s        = ~winner_s;
                    ram_address_s = winner_s ? addr_1 : addr_0;
                    ram_in_s      = winner_s ? wdata_1 : wdata_0;
                    ram_load_s    = winner_s ? we_1 : we_0;
                    state_s       = ST_ACC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACC: begin
                // ram_out is valid now for a read; a write commits at this edge.
                state_s = ST_IDLE;
                if (owner_r) begin
                    ack_1_s = 1'b1;
                    if (!ram_load_r) begin
                        rdata_1_s = ram_out;
                    end else begin
                        rdata_1_s = rdata_1_r;
                    end
                end else begin
                    ack_0_s = 1'b1;
                    if (!ram_load_r) begin
                        rdata_0_s = ram_out;
                    end else begin
                        rdata_0_s = rdata_0_r;
                    end
                end
            end
            default: begin
                state_s = RESET_STATE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= RESET_STATE;
            cnt_r         <= 7'd0;
            prio_r        <= 1'b0;
            owner_r       <= 1'b0;
            ram_address_r <= 6'd0;
            ram_in_r      <= INIT_VALUE;
            ram_load_r    <= 1'b0;
            ack_0_r       <= 1'b0;
            ack_1_r       <= 1'b0;
            rdata_0_r     <= 16'h0000;
            rdata_1_r     <= 16'h0000;
            busy_r        <= 1'b1;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            prio_r        <= prio_s;
            owner_r       <= owner_s;
            ram_address_r <= ram_address_s;
            ram_in_r      <= ram_in_s;
            ram_load_r    <= ram_load_s;
            ack_0_r       <= ack_0_s;
            ack_1_r       <= ack_1_s;
            rdata_0_r     <= rdata_0_s;
            rdata_1_r     <= rdata_1_s;
            busy_r        <= busy_s;
        end
    end

    assign ram_address = ram_address_r;
    assign ram_in      = ram_in_r;
    assign ram_load    = ram_load_r;
    assign ack_0       = ack_0_r;
    assign ack_1       = ack_1_r;
    assign rdata_0     = rdata_0_r;
    assign rdata_1     = rdata_1_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_ram64_arbiter.sv
// Self-checking bench for ram64_arbiter: directed scenarios plus randomized
// two-requester traffic, checked against a word-level memory model.
module tb_ram64_arbiter;

    logic        clk = 1'b0;
    logic        rst_n, req_0, we_0, req_1, we_1, ack_0, ack_1, ram_load, busy;
    logic [5:0]  addr_0, addr_1, ram_address;
    logic [15:0] wdata_0, wdata_1, rdata_0, rdata_1, ram_in, ram_out;

    logic        b_rst_n, b_req_0, b_we_0, b_req_1, b_we_1, b_ack_0, b_ack_1, b_ram_load, b_busy;
    logic [5:0]  b_addr_0, b_addr_1, b_ram_address;
    logic [15:0] b_wdata_0, b_wdata_1, b_rdata_0, b_rdata_1, b_ram_in, b_ram_out;

    logic [15:0] mem_a [64];
    logic [15:0] mem_b [64];
    logic [15:0] ref_mem [64];

    int   tests_run = 0;
    int   tests_failed = 0;
    int   acks_0 = 0;
    int   acks_1 = 0;
    int   load_cnt = 0;
    logic exp_prio = 1'b0;

    // 100 MHz clock.
    always #5 clk = ~clk;

    ram64_arbiter #(.CLEAR_ON_RESET(1'b1), .INIT_VALUE(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0), .ack_0(ack_0), .rdata_0(rdata_0),
        .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1), .ack_1(ack_1), .rdata_1(rdata_1),
        .ram_in(ram_in), .ram_load(ram_load), .ram_address(ram_address), .ram_out(ram_out), .busy(busy)
    );

    ram64_arbiter #(.CLEAR_ON_RESET(1'b0), .INIT_VALUE(16'h0000)) dut_b (
        .clk(clk), .rst_n(b_rst_n),
        .req_0(b_req_0), .we_0(b_we_0), .addr_0(b_addr_0), .wdata_0(b_wdata_0), .ack_0(b_ack_0), .rdata_0(b_rdata_0),
        .req_1(b_req_1), .we_1(b_we_1), .addr_1(b_addr_1), .wdata_1(b_wdata_1), .ack_1(b_ack_1), .rdata_1(b_rdata_1),
        .ram_in(b_ram_in), .ram_load(b_ram_load), .ram_address(b_ram_address), .ram_out(b_ram_out), .busy(b_busy)
    );

    // RAM64 models: combinational read, write on load at the clock edge, no reset.
    assign ram_out   = mem_a[ram_address];
    assign b_ram_out = mem_b[b_ram_address];
    always @(posedge clk) if (ram_load) mem_a[ram_address] <= ram_in;
    always @(posedge clk) if (b_ram_load) mem_b[b_ram_address] <= b_ram_in;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transaction-level monitor: ack order defines access order for the model.
    always @(negedge clk) begin
        if (ram_load) load_cnt++;
        if (ack_0 || ack_1) check("ack_exclusive", {ack_0, ack_1}, ack_0 ? 2'b10 : 2'b01);
        if (ack_0) begin
            acks_0++;
            exp_prio = 1'b1;
            if (!we_0) check("rd0_data", rdata_0, ref_mem[addr_0]);
            else ref_mem[addr_0] = wdata_0;
        end
        if (ack_1) begin
            acks_1++;
            exp_prio = 1'b0;
            if (!we_1) check("rd1_data", rdata_1, ref_mem[addr_1]);
            else ref_mem[addr_1] = wdata_1;
        end
    end

    task automatic set_req(input int sel, input logic r, input logic we, input logic [5:0] a, input logic [15:0] d);
        case (sel)
            0: begin req_0 = r; we_0 = we; addr_0 = a; wdata_0 = d; end
            1: begin req_1 = r; we_1 = we; addr_1 = a; wdata_1 = d; end
            default: begin b_req_0 = r; b_we_0 = we; b_addr_0 = a; b_wdata_0 = d; end
        endcase
    endtask

    // Counts edges from the request until the ack is seen (bounded).
    task automatic wait_ack(input int sel, output int lat);
        logic seen;
        seen = 1'b0;
        lat = 0;
        while (!seen && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            case (sel)
                0: seen = ack_0;
                1: seen = ack_1;
                default: seen = b_ack_0;
            endcase
        end
        check("ack_seen", seen, 1'b1);
    endtask

    task automatic do_access(input int sel, input logic we, input logic [5:0] a, input logic [15:0] d, output int lat);
        @(posedge clk); #1;
        set_req(sel, 1'b1, we, a, d);
        wait_ack(sel, lat);
        @(posedge clk); #1;
        set_req(sel, 1'b0, we, a, d);
    endtask

    // Called in the first cycle after reset release of the sweeping instance.
    task automatic sweep_check();
        logic [5:0] ka;
        @(negedge clk);
        check("sweep_setup", {busy, ram_load, ack_0, ack_1, rdata_0, rdata_1}, {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000});
        for (int k = 0; k < 64; k++) begin
            ka = k[5:0];
            @(negedge clk);
            check("sweep_step", {busy, ram_load, ram_address, ram_in, ack_0, ack_1}, {1'b1, 1'b1, ka, 16'h0000, 1'b0, 1'b0});
        end
        @(negedge clk);
        check("sweep_done", {busy, ram_load}, 2'b00);
        for (int i = 0; i < 64; i++) ref_mem[i] = 16'h0000;
        exp_prio = 1'b0;
    endtask

    task automatic rnd_driver(input int sel, input int n);
        int lat;
        int gap;
        logic we;
        logic [5:0] a;
        logic [15:0] d;
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = 6'($urandom_range(0, 7));
            d  = 16'($urandom);
            set_req(sel, 1'b1, we, a, d);
            wait_ack(sel, lat);
            check("rnd_latency_2_to_4", (lat >= 2 && lat <= 4), 1'b1);
            @(posedge clk); #1;
            set_req(sel, 1'b0, we, a, d);
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    // Global time limit.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, base0, base1, lc, t0, t1, got, n0, n1, last_t;
        logic exp_w;
        rst_n = 1'b0; b_rst_n = 1'b0;
        set_req(0, 1'b0, 1'b0, 6'd0, 16'h0000);
        set_req(1, 1'b0, 1'b0, 6'd0, 16'h0000);
        set_req(2, 1'b0, 1'b0, 6'd0, 16'h0000);
        b_req_1 = 1'b0; b_we_1 = 1'b0; b_addr_1 = 6'd0; b_wdata_1 = 16'h0000;
        for (int i = 0; i < 64; i++) ref_mem[i] = 16'h0000;

        // Reset values, sweep, and a request held through the sweep.
        repeat (2) @(posedge clk);
        #1;
        check("reset_values", {busy, ram_load, ram_address, ram_in, ack_0, ack_1, rdata_0, rdata_1},
              {1'b1, 1'b0, 6'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000});
        rst_n = 1'b1;
        set_req(0, 1'b1, 1'b0, 6'd37, 16'h0000);
        sweep_check();
        wait_ack(0, lat);
        check("t1_lat", lat, 2);
        check("t1_rd37", rdata_0, 16'h0000);
        @(posedge clk); #1;
        req_0 = 1'b0;

        // Write then read addr 10 from requester 0.
        base0 = acks_0;
        lc = load_cnt;
        do_access(0, 1'b1, 6'd10, 16'h300a, lat);
        check("t2_wr_lat", lat, 2);
        check("t2_load_once", load_cnt - lc, 1);
        check("t2_rdata_hold", rdata_0, 16'h0000);
        lc = load_cnt;
        do_access(0, 1'b0, 6'd10, 16'h0000, lat);
        check("t2_rd_lat", lat, 2);
        check("t2_rd10", rdata_0, 16'h300a);
        check("t2_rd_noload", load_cnt - lc, 0);
        repeat (4) @(negedge clk);
        check("t2_no_repeat_ack", acks_0 - base0, 2);

        // Reset during the ACC of a write: write commits, no ack, sweep restarts.
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b1, 6'd63, 16'h7063);
        @(posedge clk); #1;
        rst_n = 1'b0;
        req_0 = 1'b0;
        @(negedge clk);
        check("t5_acc_drive", {ram_load, ram_address, ram_in}, {1'b1, 6'd63, 16'h7063});
        @(posedge clk); #1;
        check("t5_commit", mem_a[63], 16'h7063);
        check("t5_no_ack", ack_0, 1'b0);
        rst_n = 1'b1;
        sweep_check();
        do_access(1, 1'b0, 6'd63, 16'h0000, lat);
        check("t5_rd63", rdata_1, 16'h0000);

        // Simultaneous requests, prio 0: requester 0 first.
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b1, 6'd25, 16'h4025);
        set_req(1, 1'b1, 1'b0, 6'd25, 16'h0000);
        t0 = 0; t1 = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (ack_0 && t0 == 0) t0 = n;
            if (ack_1 && t1 == 0) t1 = n;
            @(posedge clk); #1;
            if (t0 != 0) req_0 = 1'b0;
            if (t1 != 0) req_1 = 1'b0;
        end
        check("t3_ack0_cycle", t0, 3);
        check("t3_ack1_cycle", t1, 5);
        check("t3_rd25", rdata_1, 16'h4025);

        // Both hold req continuously: grants alternate every 2 cycles.
        exp_w = exp_prio;
        got = 0; n0 = 0; n1 = 0; last_t = 0;
        set_req(0, 1'b1, 1'b0, 6'd48, 16'h0000);
        set_req(1, 1'b1, 1'b0, 6'd63, 16'h0000);
        for (int c = 1; c <= 40 && got < 8; c++) begin
            @(negedge clk);
            if (ack_0 || ack_1) begin
                check("t4_order", ack_1, exp_w);
                if (got > 0) check("t4_gap", c - last_t, 2);
                last_t = c;
                exp_w = ~exp_w;
                got++;
                if (ack_0) n0++; else n1++;
            end
            @(posedge clk); #1;
            if (n0 == 4) req_0 = 1'b0;
            if (n1 == 4) req_1 = 1'b0;
        end
        check("t4_count", got, 8);

        // Randomized concurrent traffic against the memory model.
        base0 = acks_0;
        base1 = acks_1;
        fork
            rnd_driver(0, 30);
            rnd_driver(1, 30);
        join
        repeat (4) @(negedge clk);
        check("rnd_acks0", acks_0 - base0, 30);
        check("rnd_acks1", acks_1 - base1, 30);

        // No clear sweep: RAM contents survive reset.
        @(posedge clk); #1;
        b_rst_n = 1'b1;
        @(negedge clk);
        check("t6_busy_first", b_busy, 1'b1);
        @(negedge clk);
        check("t6_busy_drop", b_busy, 1'b0);
        do_access(2, 1'b1, 6'd37, 16'h5037, lat);
        check("t6_wr_lat", lat, 2);
        @(posedge clk); #1;
        b_rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t6_rst_rdata", b_rdata_0, 16'h0000);
        b_rst_n = 1'b1;
        @(negedge clk);
        check("t6_busy_first2", b_busy, 1'b1);
        @(negedge clk);
        check("t6_busy_drop2", b_busy, 1'b0);
        do_access(2, 1'b0, 6'd37, 16'h0000, lat);
        check("t6_rd_lat", lat, 2);
        check("t6_rd37", b_rdata_0, 16'h5037);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
